// File: rtl/iob_ctls_stream_pkg.sv
// Shared definitions for the streaming count-leading/trailing-symbols block:
// default parameter values and FSM state encodings.
package iob_ctls_stream_pkg;

  localparam int DEF_W     = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SKIP = 2'd2,
    OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/iob_ctls.sv
// Per-word trailing-zero counter: number of zero bits below the lowest set bit,
// W when the word is all zeros.
module iob_ctls
  import iob_ctls_stream_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0]         data,
  output logic [$clog2(W):0]   count
);

  localparam int CW1 = $clog2(W) + 1;

  // Scanning downward lets the lowest set bit overwrite every higher one.
  always_comb begin
    count = CW1'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (data[i]) count = CW1'(i);
    end
  end

endmodule

// File: rtl/iob_ctls_stream.sv
// Counts a run of zero/one symbols from either end of a multi-word frame and
// returns the saturating run length once per frame over a valid/ready stream.
module iob_ctls_stream
  import iob_ctls_stream_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  input  logic             mode_i,
  input  logic             symbol_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [W-1:0]     s_data_i,
  input  logic             s_last_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [CNT_W-1:0] m_count_o,
  output logic             m_found_o,
  output logic             m_sat_o
);

  localparam int CW     = $clog2(W);
  localparam int CW1    = CW + 1;
  localparam int CNT_W1 = CNT_W + 1;
  localparam logic [CW:0] FULL = CW1'(W);

  state_t           state, state_nxt;
  logic             mode_q, sym_q, mode_eff, sym_eff;
  logic [W-1:0]     word, word_rev, scan;
  logic [CW:0]      word_cnt;
  logic [CNT_W-1:0] acc;
  logic [CNT_W:0]   sum;
  logic             found, sat, accept, consume, all_sym;

  // MSB of the result flags that the sum was clipped to the maximum count.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                             input logic [CW:0]      b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + CNT_W1'(b);
    if (s[CNT_W]) return {1'b1, {CNT_W{1'b1}}};
    return s;
  endfunction

  assign s_ready_o = (state != OUT);
  assign m_valid_o = (state == OUT);
  assign accept    = cke_i & s_valid_i & s_ready_o;
  assign consume   = cke_i & m_valid_o & m_ready_i;

  // The first word of a frame uses the live selects; later words use the held ones.
  assign mode_eff = (state == IDLE) ? mode_i   : mode_q;
  assign sym_eff  = (state == IDLE) ? symbol_i : sym_q;

  // Leading/ones counting is mapped onto the trailing-zero counter.
  always_comb begin
    word = sym_eff ? ~s_data_i : s_data_i;
    for (int i = 0; i < W; i++) word_rev[i] = word[W-1-i];
    scan = mode_eff ? word_rev : word;
  end

  iob_ctls #(.W(W)) u_ctls (
    .data  (scan),
    .count (word_cnt)
  );

  assign all_sym = (word_cnt == FULL);
  assign sum     = sat_add(acc, word_cnt);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state <= IDLE;
    else if (cke_i) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC: if (accept) state_nxt = s_last_i ? OUT : (all_sym ? ACC : SKIP);
      SKIP:      if (accept && s_last_i) state_nxt = OUT;
      OUT:       if (consume) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      acc   <= '0;
      found <= 1'b0;
      sat   <= 1'b0;
    end else if (consume) begin
      acc   <= '0;
      found <= 1'b0;
      sat   <= 1'b0;
    end else if (accept && (state == IDLE || state == ACC)) begin
      acc <= sum[CNT_W-1:0];
      if (sum[CNT_W]) sat <= 1'b1;
      if (!all_sym)   found <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && state == IDLE) begin
      mode_q <= mode_i;
      sym_q  <= symbol_i;
    end
  end

  assign m_count_o = acc;
  assign m_found_o = found;
  assign m_sat_o   = sat;

endmodule

// File: tb/tb_iob_ctls_stream.sv
// Directed bench for iob_ctls_stream: a W=32 and a W=8/CNT_W=4 instance share
// all stimulus; frames come from a vector table plus stall/enable/reset sequences.
module tb_iob_ctls_stream;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cke = 1'b1;
  logic        mode = 1'b0, symbol = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [31:0] s_data = '0;

  logic        s_ready, m_valid, m_found, m_sat;
  logic [15:0] m_count;
  logic        s_ready8, m_valid8, m_found8, m_sat8;
  logic [3:0]  m_count8;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iob_ctls_stream #(.W(32), .CNT_W(16)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .mode_i(mode), .symbol_i(symbol),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_count_o(m_count),
    .m_found_o(m_found), .m_sat_o(m_sat)
  );

  iob_ctls_stream #(.W(8), .CNT_W(4)) dut8 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .mode_i(mode), .symbol_i(symbol),
    .s_valid_i(s_valid), .s_ready_o(s_ready8), .s_data_i(s_data[7:0]), .s_last_i(s_last),
    .m_valid_o(m_valid8), .m_ready_i(m_ready), .m_count_o(m_count8),
    .m_found_o(m_found8), .m_sat_o(m_sat8)
  );

  typedef struct {
    logic        mode;
    logic        sym;
    int          n;
    logic [31:0] d0, d1, d2;
    int          cnt;
    bit          found;
    bit          sat;
    int          cnt8;
    bit          found8;
    bit          sat8;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_count"}, 32'(m_count), 32'd0);
    check({tag, "_found"}, 32'(m_found), 32'd0);
    check({tag, "_sat"},   32'(m_sat),   32'd0);
    check({tag, "_ready"}, 32'(s_ready), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic handshake(input string tag);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(m_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(s_ready), 32'd1);
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    // mode sym n   d0            d1            d2        cnt found sat cnt8 f8 s8
    vecs[0] = '{1'b0, 1'b0, 1, 32'h0000_0100, 32'h0,        32'h0, 8,  1, 0, 8,  0, 0};
    vecs[1] = '{1'b1, 1'b1, 2, 32'hFFFF_FFFF, 32'hF000_0000, 32'h0, 36, 1, 0, 8,  1, 0};
    vecs[2] = '{1'b0, 1'b0, 3, 32'h0,         32'h0,        32'h0, 96, 0, 0, 15, 0, 1};
    vecs[3] = '{1'b1, 1'b0, 1, 32'h0001_0000, 32'h0,        32'h0, 15, 1, 0, 8,  0, 0};
    vecs[4] = '{1'b0, 1'b1, 1, 32'h0000_00FF, 32'h0,        32'h0, 8,  1, 0, 8,  0, 0};
    vecs[5] = '{1'b0, 1'b1, 2, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0, 34, 1, 0, 10, 1, 0};
    vecs[6] = '{1'b1, 1'b0, 2, 32'h0,         32'h8000_0000, 32'h0, 32, 1, 0, 15, 0, 1};
    vecs[7] = '{1'b0, 1'b0, 3, 32'h1,         32'h0,        32'h0, 0,  1, 0, 0,  1, 0};
    vecs[8] = '{1'b0, 1'b0, 3, 32'h0,         32'h0000_0400, 32'h0, 42, 1, 0, 15, 0, 1};
    vecs[9] = '{1'b1, 1'b1, 1, 32'hFFFF_0000, 32'h0,        32'h0, 16, 1, 0, 0,  1, 0};

    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    arst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_release");

    // Selects are inverted after the first word to prove they are held per frame.
    for (int v = 0; v < 10; v++) begin
      string tag;
      logic [31:0] words[3];
      tag = $sformatf("vec%0d", v);
      words[0] = vecs[v].d0; words[1] = vecs[v].d1; words[2] = vecs[v].d2;
      mode   = vecs[v].mode;
      symbol = vecs[v].sym;
      for (int w = 0; w < vecs[v].n; w++) begin
        check({tag, "_sready"}, 32'(s_ready), 32'd1);
        send(words[w], w == vecs[v].n - 1);
        if (w == 0) begin
          mode   = ~mode;
          symbol = ~symbol;
        end
      end
      check({tag, "_valid"},  32'(m_valid),  32'd1);
      check({tag, "_count"},  32'(m_count),  32'(vecs[v].cnt));
      check({tag, "_found"},  32'(m_found),  32'(vecs[v].found));
      check({tag, "_sat"},    32'(m_sat),    32'(vecs[v].sat));
      check({tag, "_count8"}, 32'(m_count8), 32'(vecs[v].cnt8));
      check({tag, "_found8"}, 32'(m_found8), 32'(vecs[v].found8));
      check({tag, "_sat8"},   32'(m_sat8),   32'(vecs[v].sat8));
      handshake(tag);
    end

    // Stalled result: 0x1, 0x0, 0x0 with a new word offered during the stall.
    mode = 1'b0; symbol = 1'b0;
    send(32'h1, 1'b0);
    send(32'h0, 1'b0);
    send(32'h0, 1'b1);
    s_valid = 1'b1; s_data = 32'h0000_0100; s_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid",  32'(m_valid), 32'd1);
      check("stall_sready", 32'(s_ready), 32'd0);
      check("stall_count",  32'(m_count), 32'd0);
      check("stall_found",  32'(m_found), 32'd1);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("stall_hs_valid", 32'(m_valid), 32'd0);
    check("stall_hs_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("next_valid", 32'(m_valid), 32'd1);
    check("next_count", 32'(m_count), 32'd8);
    check("next_found", 32'(m_found), 32'd1);
    handshake("next");

    // Clock enable low: offered word ignored, pending result held.
    cke = 1'b0;
    s_valid = 1'b1; s_data = 32'h0; s_last = 1'b0;
    repeat (2) @(negedge clk);
    check("cke_idle_valid", 32'(m_valid), 32'd0);
    cke = 1'b1;
    send(32'h0000_0010, 1'b1);
    check("cke_count", 32'(m_count), 32'd4);
    check("cke_found", 32'(m_found), 32'd1);
    cke = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("cke_hold_valid", 32'(m_valid), 32'd1);
    check("cke_hold_count", 32'(m_count), 32'd4);
    cke = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("cke_release_valid", 32'(m_valid), 32'd0);

    // Reset asserted after 2 of 4 words.
    send(32'h0, 1'b0);
    send(32'h0, 1'b0);
    #2 arst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_result", 32'(m_valid), 32'd0);
    send(32'h0000_0010, 1'b1);
    check("fresh_valid", 32'(m_valid), 32'd1);
    check("fresh_count", 32'(m_count), 32'd4);
    check("fresh_found", 32'(m_found), 32'd1);
    check("fresh_sat",   32'(m_sat),   32'd0);
    handshake("fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_ctls_stream.md
IOB_CTLS_STREAM -- requirements
Module: iob_ctls_stream

Interface
REQ-001 SHALL have parameter W, default 32: data word width in bits, W >= 2.
REQ-002 SHALL have parameter CNT_W, default 16: result count width in bits, CNT_W > $clog2(W).
REQ-003 SHALL have ports, in order:
- clk_i  input  1  clock, rising edge.
- arst_n_i  input  1  asynchronous active-low reset.
- cke_i  input  1  clock enable; when low, all state holds.
- mode_i  input  1  0 = trailing (from bit 0), 1 = leading (from bit W-1).
- symbol_i  input  1  0 = count zeros, 1 = count ones.
- s_valid_i  input  1  input word valid.
- s_ready_o  output  1  input word accepted when high with s_valid_i.
- s_data_i  input  W  input word.
- s_last_i  input  1  marks the final word of a frame.
- m_valid_o  output  1  result valid.
- m_ready_i  input  1  result consumed when high with m_valid_o.
- m_count_o  output  CNT_W  symbol run length for the frame.
- m_found_o  output  1  1 = a non-symbol bit terminated the run; 0 = the whole frame was symbols.
- m_sat_o  output  1  1 = count saturated.

Function
REQ-004 SHALL count consecutive symbol bits across a multi-word frame, starting at the first word of the frame.
REQ-005 SHALL scan each word from bit 0 in trailing mode and from bit W-1 in leading mode.
REQ-006 SHALL accept a word on a clock edge where cke_i=1, s_valid_i=1 and s_ready_o=1.
REQ-007 SHALL sample mode_i and symbol_i with the first word of a frame and hold them internally until the result is consumed.
REQ-008 SHALL compute the per-word count combinationally, with width $clog2(W)+1 and range 0..W.
REQ-009 SHALL run the FSM states IDLE, ACC, SKIP and OUT.
- IDLE to ACC: first word accepted, word is all symbols, s_last_i=0.
- IDLE to SKIP: first word accepted, word contains a non-symbol, s_last_i=0.
- IDLE or ACC to OUT: last word accepted.
- ACC to SKIP: accepted word contains a non-symbol, s_last_i=0.
- SKIP to OUT: last word accepted.
- OUT to IDLE: m_valid_o and m_ready_i both high.
REQ-010 SHALL, in ACC and IDLE, add the per-word count to the accumulator and set the found flag when that count is less than W.
REQ-011 SHALL, in SKIP, accept and discard words without changing the accumulator.
REQ-012 SHALL saturate the accumulator at 2^CNT_W-1 and set m_sat_o when saturation occurs.
REQ-013 SHALL drive s_ready_o=1 in IDLE, ACC and SKIP, and s_ready_o=0 in OUT.
REQ-014 SHALL assert m_valid_o only in OUT, one cycle after the last word is accepted; m_count_o, m_found_o and m_sat_o SHALL be stable while m_valid_o=1 and m_ready_i=0.
REQ-015 SHALL treat a single-word frame (s_last_i=1 on the first word) as going straight from IDLE to OUT.
REQ-016 SHALL clear the accumulator, found flag and saturation flag on the transition from OUT to IDLE.
REQ-017 SHALL NOT accept an input word in the same cycle that a result is consumed; the next frame starts no earlier than the following cycle.
REQ-018 SHALL freeze all state and outputs while cke_i=0.

Reset
REQ-019 SHALL, while arst_n_i=0, asynchronously force state IDLE and accumulator 0.
REQ-020 SHALL drive these reset output values: m_valid_o=0, m_count_o=0, m_found_o=0, m_sat_o=0, s_ready_o=1.
REQ-021 SHALL abandon any partial frame or pending result when reset is asserted mid-operation, with no output produced for it.

Structure
REQ-022 SHALL use iob_ctls as the single per-word counting sub-module, with one instance per supported combination of mode and symbol selected by the held mode and symbol, or with runtime inversion and reversal in front of a single instance.
REQ-023 SHALL place the FSM state encodings and the default parameter values in a shared package or include file.
REQ-024 SHALL be implementable in 120-400 lines of RTL and SHALL contain no latches.

Verification
REQ-025 Scenario 1: W=32, trailing, zeros; single word 0x0000_0100 with last=1 -> count 8, found 1, sat 0.
REQ-026 Scenario 2: W=32, leading, ones; words 0xFFFF_FFFF then 0xF000_0000 (last) -> count 36, found 1.
REQ-027 Scenario 3: W=32, trailing, zeros; three all-zero words, third with last=1 -> count 96, found 0.
REQ-028 Scenario 4: W=8, CNT_W=4, trailing, zeros; three all-zero words -> count 15, sat 1.
REQ-029 Scenario 5: frame 0x1, 0x0, 0x0 (last) with m_ready_i held low for 5 cycles:
- count 0, found 1.
- Outputs are stable during the stall.
- s_ready_o=0 during the stall.
- The next frame is accepted the cycle after the handshake.
REQ-030 Scenario 6: arst_n_i pulsed low after 2 of 4 words of a frame -> all outputs return to reset values, and a fresh frame 0x0000_0010 (last) gives count 4.
